divider: RTL and testbench



---
 rtl/divider_pkg.sv | 23 ++
 rtl/divider_if.sv | 28 ++
 rtl/divider_div_step.sv | 23 ++
 rtl/divider.sv | 179 +++++++++++++++++
 tb/tb_divider.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the divider: state encodings and a constant clog2 helper.
package divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Number of bits needed to hold values 0 .. value-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned res;
    res = 0;
    v   = (value > 1) ? value - 1 : 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Trigger/ready/done handshake plus operand and result bus of the divider.
interface divider_if #(
  parameter int unsigned C_WIDTH = 16
);

  logic               trigger;
  logic [C_WIDTH-1:0] a;
  logic [C_WIDTH-1:0] b;
  logic [C_WIDTH-1:0] y;
  logic [C_WIDTH-1:0] r;
  logic               ready;
  logic               done;
  logic               div_zero;
  logic               overflow;

  // Requester side: issues operands and trigger, observes results.
  modport master (
    output trigger, a, b,
    input  y, r, ready, done, div_zero, overflow
  );

  // Divider side.
  modport slave (
    input  trigger, a, b,
    output y, r, ready, done, div_zero, overflow
  );

endinterface

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational so it can be replicated for unrolled or pipelined variants.
module divider_div_step #(
  parameter int unsigned C_WIDTH = 16
) (
  input  logic [C_WIDTH-1:0] i_rem,
  input  logic               i_bit,
  input  logic [C_WIDTH-1:0] i_div,
  output logic [C_WIDTH-1:0] o_rem_c,
  output logic               o_q_bit_c
);

  // The shifted remainder needs one extra bit; the result always fits back in
  // C_WIDTH because the incoming remainder is strictly less than the divisor.
  logic [C_WIDTH:0] w_shift;
  logic [C_WIDTH:0] w_diff;

  assign w_shift   = {i_rem, i_bit};
  assign w_diff    = w_shift - {1'b0, i_div};
  assign o_q_bit_c = (w_shift >= {1'b0, i_div});
  assign o_rem_c   = C_WIDTH'(o_q_bit_c ? w_diff : w_shift);

endmodule

// File: rtl/divider.sv
// Unsigned sequential radix-2 restoring divider, one quotient bit per clock.
// Quotient = (a << FIXED_POINT) / b, remainder = (a << FIXED_POINT) % b.
// Optional macro DIVIDER_SATURATE_EN: saturate y to all-ones on overflow
// (default: truncate the quotient to C_WIDTH bits).
module divider
  import divider_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 16,
  parameter int unsigned FIXED_POINT = 0
) (
  input  logic      ctl_clk,
  input  logic      reset,
  divider_if.slave  bus
);

  localparam int unsigned N     = C_WIDTH + FIXED_POINT;
  localparam int unsigned CNT_W = clog2(N + 1);
`ifdef DIVIDER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Reject fractional widths that leave no integer quotient bits.
  if (FIXED_POINT >= C_WIDTH) begin : g_bad_param
    $error("divider: FIXED_POINT must be smaller than C_WIDTH");
  end

  div_state_e         r_state;
  div_state_e         w_next_state;

  logic [N-1:0]       r_dvd;       // dividend shifts out the top, quotient shifts in the bottom
  logic [C_WIDTH-1:0] r_div;
  logic [C_WIDTH-1:0] r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dz_op;     // current operation is a divide by zero

  logic [C_WIDTH-1:0] r_y;
  logic [C_WIDTH-1:0] r_r;
  logic               r_ready;
  logic               r_done;
  logic               r_div_zero;
  logic               r_overflow;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [C_WIDTH-1:0] w_step_rem;
  logic               w_q_bit;
  logic [N-1:0]       w_quo;
  logic               w_ovf;
  logic [C_WIDTH-1:0] w_y;

  divider_div_step #(
    .C_WIDTH (C_WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[N-1]),
    .i_div     (r_div),
    .o_rem_c   (w_step_rem),
    .o_q_bit_c (w_q_bit)
  );

  // Dividend register after this iteration; on the last iteration it is the full quotient.
  assign w_quo = N'({r_dvd, w_q_bit});

  // Overflow when any quotient bit above C_WIDTH is set (impossible without fraction bits).
  if (FIXED_POINT == 0) begin : g_no_frac
    assign w_ovf = 1'b0;
  end else begin : g_frac
    assign w_ovf = |w_quo[N-1:C_WIDTH];
  end

  assign w_y = (SATURATE && w_ovf) ? '1 : w_quo[C_WIDTH-1:0];

  // State register.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (bus.trigger) begin
          w_load       = 1'b1;
          w_next_state = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last       = 1'b1;
          w_next_state = DIV_DONE;
        end
      end
      DIV_DONE: begin
        w_next_state = DIV_IDLE;
      end
      default: begin
        w_next_state = DIV_IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they track the state register.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next_state == DIV_IDLE);
      r_done  <= (w_next_state == DIV_DONE);
    end
  end

  // Operand capture and shift/subtract iterations.
  // A zero divisor takes a single pass through BUSY so its result lands one edge after capture.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_dz_op <= 1'b0;
    end else if (w_load) begin
      r_dvd   <= N'(bus.a) << FIXED_POINT;
      r_div   <= bus.b;
      r_rem   <= '0;
      r_cnt   <= (bus.b == '0) ? CNT_W'(1) : CNT_W'(N);
      r_dz_op <= (bus.b == '0);
    end else if (w_step) begin
      r_dvd   <= w_quo;
      r_rem   <= w_step_rem;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Result and status registers: cleared flags at capture, results written on the final iteration.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_y        <= '0;
      r_r        <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      if (r_dz_op) begin
        r_y        <= '1;
        r_r        <= r_dvd[N-1 -: C_WIDTH];
        r_div_zero <= 1'b1;
        r_overflow <= 1'b0;
      end else begin
        r_y        <= w_y;
        r_r        <= w_step_rem;
        r_div_zero <= 1'b0;
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.y        = r_y;
  assign bus.r        = r_r;
  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: two instances (C_WIDTH=8 with FIXED_POINT 0 and 4)
// against an arithmetic reference model, plus directed literal checks.
module tb_divider;

  localparam int unsigned W = 8;
`ifdef DIVIDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_if #(.C_WIDTH(W)) if0 ();
  divider_if #(.C_WIDTH(W)) if1 ();

  logic [1:0]   tb_trig;
  logic [W-1:0] tb_a [2];
  logic [W-1:0] tb_b [2];

  logic [1:0]   o_ready, o_done, o_dz, o_ov;
  logic [W-1:0] o_y [2];
  logic [W-1:0] o_r [2];

  assign if0.trigger = tb_trig[0];
  assign if0.a       = tb_a[0];
  assign if0.b       = tb_b[0];
  assign if1.trigger = tb_trig[1];
  assign if1.a       = tb_a[1];
  assign if1.b       = tb_b[1];

  assign o_ready = {if1.ready, if0.ready};
  assign o_done  = {if1.done, if0.done};
  assign o_dz    = {if1.div_zero, if0.div_zero};
  assign o_ov    = {if1.overflow, if0.overflow};
  assign o_y[0]  = if0.y;
  assign o_y[1]  = if1.y;
  assign o_r[0]  = if0.r;
  assign o_r[1]  = if1.r;

  divider #(.C_WIDTH(W), .FIXED_POINT(0)) u_div0 (.ctl_clk(clk), .reset(rst_n), .bus(if0));
  divider #(.C_WIDTH(W), .FIXED_POINT(4)) u_div1 (.ctl_clk(clk), .reset(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int fp_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic void calc(input int fp, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] y, output logic [W-1:0] r,
                               output bit dz, output bit ov);
    int unsigned num, q;
    num = 32'(a) << fp;
    if (b == '0) begin
      y = '1; r = a; dz = 1'b1; ov = 1'b0;
    end else begin
      q  = num / 32'(b);
      r  = W'(num % 32'(b));
      ov = (q > 32'd255);
      y  = (ov && SAT) ? 8'hFF : W'(q);
      dz = 1'b0;
    end
  endfunction

  // Behavioural timing model: a capture starts a countdown of N (or 1 for b==0) edges.
  bit           m_ready [2];
  bit           m_done  [2];
  bit           m_dz    [2];
  bit           m_ov    [2];
  logic [W-1:0] m_y     [2];
  logic [W-1:0] m_r     [2];
  int           m_left  [2];
  logic [W-1:0] p_y     [2];
  logic [W-1:0] p_r     [2];
  bit           p_dz    [2];
  bit           p_ov    [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_ready[d] = 1'b1; m_done[d] = 1'b0; m_dz[d] = 1'b0; m_ov[d] = 1'b0;
        m_y[d] = '0; m_r[d] = '0; m_left[d] = 0;
      end else if (m_done[d]) begin
        m_done[d]  = 1'b0;
        m_ready[d] = 1'b1;
      end else if (m_ready[d]) begin
        if (tb_trig[d]) begin
          calc(fp_of(d), tb_a[d], tb_b[d], p_y[d], p_r[d], p_dz[d], p_ov[d]);
          m_left[d]  = (tb_b[d] == '0) ? 1 : int'(W) + fp_of(d);
          m_ready[d] = 1'b0;
          m_dz[d]    = 1'b0;
          m_ov[d]    = 1'b0;
        end
      end else begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_done[d] = 1'b1;
          m_y[d] = p_y[d]; m_r[d] = p_r[d]; m_dz[d] = p_dz[d]; m_ov[d] = p_ov[d];
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready[%0d]", d), 32'(o_ready[d]), 32'(m_ready[d]));
      chk($sformatf("done[%0d]", d), 32'(o_done[d]), 32'(m_done[d]));
      chk($sformatf("div_zero[%0d]", d), 32'(o_dz[d]), 32'(m_dz[d]));
      chk($sformatf("overflow[%0d]", d), 32'(o_ov[d]), 32'(m_ov[d]));
      if (m_done[d] || m_ready[d]) begin
        chk($sformatf("y[%0d]", d), 32'(o_y[d]), 32'(m_y[d]));
        chk($sformatf("r[%0d]", d), 32'(o_r[d]), 32'(m_r[d]));
      end
    end
  end

  task automatic wait_ready(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_ready[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk($sformatf("ready_timeout[%0d]", d), 32'd0, 32'd1);
  endtask

  // Directed divide with literal expectations on latency and results.
  task automatic do_op(input string nm, input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input logic [W-1:0] ey, input logic [W-1:0] er,
                       input bit edz, input bit eov, input bit noise);
    int cyc;
    bit got;
    wait_ready(d);
    tb_a[d] = a; tb_b[d] = b; tb_trig[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_trig[d] = 1'b0; tb_a[d] = W'($urandom); tb_b[d] = W'($urandom);
    cyc = 0; got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (o_done[d]) begin
        got = 1'b1;
        cyc = i;
      end else if (noise && i == 2) begin
        tb_trig[d] = 1'b1; tb_a[d] = W'($urandom); tb_b[d] = W'($urandom);
      end else if (noise && i == 3) begin
        tb_trig[d] = 1'b0;
      end
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    if (got) begin
      chk({nm, "_y"}, 32'(o_y[d]), 32'(ey));
      chk({nm, "_r"}, 32'(o_r[d]), 32'(er));
      chk({nm, "_div_zero"}, 32'(o_dz[d]), 32'(edz));
      chk({nm, "_overflow"}, 32'(o_ov[d]), 32'(eov));
      @(posedge clk);
      #1;
      chk({nm, "_ready_after"}, 32'(o_ready[d]), 32'd1);
      chk({nm, "_done_drop"}, 32'(o_done[d]), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ty, tr, a, b;
    bit tdz, tov;
    int last, n, bsel, d;

    tb_trig = '0;
    tb_a[0] = '0; tb_b[0] = '0; tb_a[1] = '0; tb_b[1] = '0;

    // Pin the model against hand-computed values.
    calc(4, 8'h03, 8'h02, ty, tr, tdz, tov);
    chk("model_q4_y", 32'(ty), 32'h18);
    chk("model_q4_ov", 32'(tov), 32'd0);
    calc(0, 8'hFF, 8'h10, ty, tr, tdz, tov);
    chk("model_ff_r", 32'(tr), 32'h0F);
    calc(4, 8'hFF, 8'h01, ty, tr, tdz, tov);
    chk("model_ovf_y", 32'(ty), SAT ? 32'hFF : 32'hF0);

    // Reset state while reset is held.
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(o_ready[i]), 32'd1);
      chk("rst_done", 32'(o_done[i]), 32'd0);
      chk("rst_y", 32'(o_y[i]), 32'd0);
      chk("rst_flags", 32'({o_dz[i], o_ov[i]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("basic", 0, 8'h06, 8'h02, 8, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op("ff_10", 0, 8'hFF, 8'h10, 8, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b1);
    do_op("small_q", 0, 8'h24, 8'h73, 8, 8'h00, 8'h24, 1'b0, 1'b0, 1'b0);
    do_op("q4_frac", 1, 8'h03, 8'h02, 12, 8'h18, 8'h00, 1'b0, 1'b0, 1'b1);
    do_op("q4_ovf", 1, 8'hFF, 8'h01, 12, SAT ? 8'hFF : 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("q4_after_ovf", 1, 8'h10, 8'h03, 12, 8'h55, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("dz", 0, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0);
    do_op("after_dz", 0, 8'h09, 8'h04, 8, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("q4_dz", 1, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0);

    // Trigger held high: back-to-back results every N+2 cycles.
    wait_ready(0);
    tb_trig[0] = 1'b1;
    last = -1; n = 0;
    for (int i = 0; i < 50; i++) begin
      tb_a[0] = W'($urandom);
      tb_b[0] = W'($urandom_range(1, 255));
      @(negedge clk);
      if (o_done[0]) begin
        if (last >= 0) chk("held_spacing", 32'(i - last), 32'd10);
        last = i;
        n++;
      end
    end
    tb_trig[0] = 1'b0;
    chk("held_count", 32'(n >= 4), 32'd1);

    // Randomized operations on both instances.
    for (int i = 0; i < 40; i++) begin
      d    = i % 2;
      a    = W'($urandom);
      bsel = $urandom_range(0, 9);
      b    = (bsel == 0) ? 8'h00 : ((bsel < 3) ? W'($urandom_range(1, 3)) : W'($urandom));
      wait_ready(d);
      tb_a[d] = a; tb_b[d] = b; tb_trig[d] = 1'b1;
      @(negedge clk);
      tb_trig[d] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_ready(0);
    wait_ready(1);

    // Reset in the middle of a divide aborts immediately.
    do_op("pre_rst", 0, 8'h09, 8'h04, 8, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
    wait_ready(0);
    tb_a[0] = 8'h80; tb_b[0] = 8'h03; tb_trig[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_trig[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready[0]), 32'd1);
    chk("abort_done", 32'(o_done[0]), 32'd0);
    chk("abort_y", 32'(o_y[0]), 32'd0);
    chk("abort_r", 32'(o_r[0]), 32'd0);
    chk("abort_flags", 32'({o_dz[0], o_ov[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op("post_rst", 0, 8'h80, 8'h03, 8, 8'h2A, 8'h02, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
